// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb)
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT and raise illegal_inst.
module mc_control_fsm #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   input  logic       br_taken,
   output logic       imem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic       alu_src_imm,
   output logic [1:0] alu_op,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       instr_retired,
   output logic       timeout_err,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   output logic       illegal_inst,
`endif
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_NOP,
      C_R,
      C_I,
      C_LD,
      C_ST,
      C_BR,
      C_JAL,
      C_JALR,
      C_ILL
   } cls_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   cls_t             cls;
   cls_t             cls_dec;
   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;
   logic             timeout_hit;
   logic             timeout_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic             ill_hit;
   logic             ill_q;
`endif

   // funct3 is consumed by the ALU decoder; the sequencer only needs the opcode class.
   logic unused_funct3;
   assign unused_funct3 = ^funct3;

   always_comb begin
      cls_dec = C_ILL;
      case (opcode)
         7'b0110011: cls_dec = C_R;
         7'b0010011: cls_dec = C_I;
         7'b0000011: cls_dec = C_LD;
         7'b0100011: cls_dec = C_ST;
         7'b1100011: cls_dec = C_BR;
         7'b1101111: cls_dec = C_JAL;
         7'b1100111: cls_dec = C_JALR;
         default:    cls_dec = C_ILL;
      endcase
   end

   assign waiting = ((state == S_FETCH) && !imem_ready) ||
                    ((state == S_MEM)   && !dmem_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Wait counter restarts on every state change, so each FETCH/MEM visit gets a fresh budget.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
         cls       <= C_NOP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         ill_q     <= 1'b0;
`endif
      end else begin
         if (state_next != state) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (timeout_hit) begin
            timeout_q <= 1'b1;
         end
         if (state == S_DECODE) begin
            cls <= cls_dec;
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         if (ill_hit) begin
            ill_q <= 1'b1;
         end
`endif
      end
   end

   always_comb begin
      state_next    = state;
      timeout_hit   = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ill_hit       = 1'b0;
`endif
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_sel        = 2'b00;
      alu_src_imm   = 1'b0;
      alu_op        = 2'b00;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'b00;
      instr_retired = 1'b0;

      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write   = 1'b1;
               state_next = S_DECODE;
            end else if (wait_cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = S_HALT;
            end
         end

         S_DECODE: begin
            state_next = S_EXEC;
         end

         S_EXEC: begin
            case (cls)
               C_R: begin
                  alu_op     = 2'b10;
                  state_next = S_WB;
               end
               C_I: begin
                  alu_src_imm = 1'b1;
                  alu_op      = 2'b10;
                  state_next  = S_WB;
               end
               C_LD, C_ST: begin
                  alu_src_imm = 1'b1;
                  alu_op      = 2'b00;
                  state_next  = S_MEM;
               end
               C_BR: begin
                  alu_op        = 2'b01;
                  pc_write      = 1'b1;
                  pc_sel        = br_taken ? 2'b01 : 2'b00;
                  instr_retired = 1'b1;
                  state_next    = S_FETCH;
               end
               C_JAL: begin
                  state_next = S_WB;
               end
               C_JALR: begin
                  alu_src_imm = 1'b1;
                  alu_op      = 2'b00;
                  state_next  = S_WB;
               end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               C_ILL: begin
                  ill_hit    = 1'b1;
                  state_next = S_HALT;
               end
`endif
               default: begin
                  // Unrecognised class retires as a NOP: just step the PC.
                  pc_write      = 1'b1;
                  pc_sel        = 2'b00;
                  instr_retired = 1'b1;
                  state_next    = S_FETCH;
               end
            endcase
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls == C_ST);
            if (dmem_ready) begin
               if (cls == C_ST) begin
                  pc_write      = 1'b1;
                  pc_sel        = 2'b00;
                  instr_retired = 1'b1;
                  state_next    = S_FETCH;
               end else begin
                  state_next = S_WB;
               end
            end else if (wait_cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = S_HALT;
            end
         end

         S_WB: begin
            reg_write     = 1'b1;
            pc_write      = 1'b1;
            instr_retired = 1'b1;
            state_next    = S_FETCH;
            case (cls)
               C_LD: begin
                  wb_sel = 2'b01;
                  pc_sel = 2'b00;
               end
               C_JAL: begin
                  wb_sel = 2'b10;
                  pc_sel = 2'b01;
               end
               C_JALR: begin
                  wb_sel      = 2'b10;
                  pc_sel      = 2'b10;
                  alu_src_imm = 1'b1;
               end
               default: begin
                  wb_sel = 2'b00;
                  pc_sel = 2'b00;
               end
            endcase
         end

         S_HALT: begin
            state_next = S_HALT;
         end

         default: begin
            state_next = S_FETCH;
         end
      endcase

      state_o     = state;
      timeout_err = timeout_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_inst = ill_q;
`endif

      // While reset is held every output reads zero, including the sticky flags.
      if (reset) begin
         imem_req      = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_sel        = 2'b00;
         alu_src_imm   = 1'b0;
         alu_op        = 2'b00;
         dmem_req      = 1'b0;
         dmem_we       = 1'b0;
         reg_write     = 1'b0;
         wb_sel        = 2'b00;
         instr_retired = 1'b0;
         timeout_err   = 1'b0;
         state_o       = 3'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         illegal_inst  = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
// Per-cycle stimulus and expected outputs are queued together, then replayed and compared.
module tb_mc_control_fsm;

   localparam int TO = 16;

   localparam int K_R    = 0;
   localparam int K_I    = 1;
   localparam int K_LD   = 2;
   localparam int K_ST   = 3;
   localparam int K_BR   = 4;
   localparam int K_JAL  = 5;
   localparam int K_JALR = 6;
   localparam int K_ILL  = 7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'h00;
   logic [2:0] funct3 = 3'b000;
   logic       imem_ready = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       br_taken = 1'b0;
   logic       imem_req;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_sel;
   logic       alu_src_imm;
   logic [1:0] alu_op;
   logic       dmem_req;
   logic       dmem_we;
   logic       reg_write;
   logic [1:0] wb_sel;
   logic       instr_retired;
   logic       timeout_err;
   logic       ill_obs;
   logic [2:0] state_o;

   typedef struct {
      logic        rst;
      logic [6:0]  opc;
      logic        ir;
      logic        dr;
      logic        bt;
      logic [18:0] exp;
   } cyc_t;

   cyc_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_ret = 0;
   int   obs_ret = 0;
   logic exp_tout = 1'b0;
   logic exp_ill = 1'b0;

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .funct3        (funct3),
      .imem_ready    (imem_ready),
      .dmem_ready    (dmem_ready),
      .br_taken      (br_taken),
      .imem_req      (imem_req),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_sel        (pc_sel),
      .alu_src_imm   (alu_src_imm),
      .alu_op        (alu_op),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .reg_write     (reg_write),
      .wb_sel        (wb_sel),
      .instr_retired (instr_retired),
      .timeout_err   (timeout_err),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      .illegal_inst  (ill_obs),
`endif
      .state_o       (state_o)
   );

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
   assign ill_obs = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   // Packed view: {state, ill, tout, retired, wb_sel, reg_write, dmem_we, dmem_req,
   //               alu_op, alu_src_imm, pc_sel, pc_write, ir_write, imem_req}
   function automatic logic [18:0] mk(input int st, input int imq, input int irw, input int pcw,
                                      input int pcs, input int src, input int aop, input int dq,
                                      input int dw, input int rw, input int wbs, input int ret);
      return {3'(st), exp_ill, exp_tout, 1'(ret), 2'(wbs), 1'(rw), 1'(dw), 1'(dq),
              2'(aop), 1'(src), 2'(pcs), 1'(pcw), 1'(irw), 1'(imq)};
   endfunction

   function automatic int kind_of(input logic [6:0] opc);
      case (opc)
         7'h33:   return K_R;
         7'h13:   return K_I;
         7'h03:   return K_LD;
         7'h23:   return K_ST;
         7'h63:   return K_BR;
         7'h6F:   return K_JAL;
         7'h67:   return K_JALR;
         default: return K_ILL;
      endcase
   endfunction

   task automatic push(input logic rst, input logic [6:0] opc, input logic ir, input logic dr,
                       input logic bt, input logic [18:0] exp);
      cyc_t c;
      c.rst = rst; c.opc = opc; c.ir = ir; c.dr = dr; c.bt = bt; c.exp = exp;
      if (exp[13]) exp_ret++;
      sbq.push_back(c);
   endtask

   task automatic gen_reset(input int n);
      for (int k = 0; k < n; k++) push(1'b1, 7'h00, 1'b1, 1'b1, 1'b0, 19'd0);
      exp_tout = 1'b0;
      exp_ill  = 1'b0;
   endtask

   // Ready inputs are held high in HALT to show they are ignored there.
   task automatic halt(input int n);
      for (int k = 0; k < n; k++) push(1'b0, 7'h33, 1'b1, 1'b1, 1'b1, mk(5,0,0,0,0,0,0,0,0,0,0,0));
   endtask

   task automatic gen_instr(input logic [6:0] opc, input int idly, input int ddly, input logic bt,
                            input logic nz, input int abort_mem);
      int kind;
      int st;
      logic do_mem;
      logic do_wb;
      kind = kind_of(opc);
      st = (kind == K_ST) ? 1 : 0;
      do_mem = 1'b0;
      do_wb = 1'b0;
      for (int k = 0; k < idly && k < TO; k++) push(1'b0, opc, 1'b0, nz, bt, mk(0,1,0,0,0,0,0,0,0,0,0,0));
      if (idly >= TO) begin
         exp_tout = 1'b1;
         halt(3);
         return;
      end
      push(1'b0, opc, 1'b1, nz, bt, mk(0,1,1,0,0,0,0,0,0,0,0,0));
      push(1'b0, opc, nz, nz, bt, mk(1,0,0,0,0,0,0,0,0,0,0,0));
      case (kind)
         K_R:    begin push(1'b0, opc, nz, nz, bt, mk(2,0,0,0,0,0,2,0,0,0,0,0)); do_wb = 1'b1; end
         K_I:    begin push(1'b0, opc, nz, nz, bt, mk(2,0,0,0,0,1,2,0,0,0,0,0)); do_wb = 1'b1; end
         K_LD,
         K_ST:   begin push(1'b0, opc, nz, nz, bt, mk(2,0,0,0,0,1,0,0,0,0,0,0)); do_mem = 1'b1; end
         K_BR:   push(1'b0, opc, nz, nz, bt, mk(2,0,0,1,int'(bt),0,1,0,0,0,0,1));
         K_JAL:  begin push(1'b0, opc, nz, nz, bt, mk(2,0,0,0,0,0,0,0,0,0,0,0)); do_wb = 1'b1; end
         K_JALR: begin push(1'b0, opc, nz, nz, bt, mk(2,0,0,0,0,1,0,0,0,0,0,0)); do_wb = 1'b1; end
         default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            push(1'b0, opc, nz, nz, bt, mk(2,0,0,0,0,0,0,0,0,0,0,0));
            exp_ill = 1'b1;
            halt(3);
            return;
`else
            push(1'b0, opc, nz, nz, bt, mk(2,0,0,1,0,0,0,0,0,0,0,1));
`endif
         end
      endcase
      if (do_mem) begin
         for (int k = 0; k < ddly && k < TO; k++) begin
            if (abort_mem >= 0 && k == abort_mem) begin
               gen_reset(1);
               return;
            end
            push(1'b0, opc, nz, 1'b0, bt, mk(3,0,0,0,0,0,0,1,st,0,0,0));
         end
         if (ddly >= TO) begin
            exp_tout = 1'b1;
            halt(3);
            return;
         end
         if (st != 0) push(1'b0, opc, nz, 1'b1, bt, mk(3,0,0,1,0,0,0,1,1,0,0,1));
         else         push(1'b0, opc, nz, 1'b1, bt, mk(3,0,0,0,0,0,0,1,0,0,0,0));
         do_wb = (st == 0);
      end
      if (do_wb) begin
         case (kind)
            K_LD:    push(1'b0, opc, nz, nz, bt, mk(4,0,0,1,0,0,0,0,0,1,1,1));
            K_JAL:   push(1'b0, opc, nz, nz, bt, mk(4,0,0,1,1,0,0,0,0,1,2,1));
            K_JALR:  push(1'b0, opc, nz, nz, bt, mk(4,0,0,1,2,1,0,0,0,1,2,1));
            default: push(1'b0, opc, nz, nz, bt, mk(4,0,0,1,0,0,0,0,0,1,0,1));
         endcase
      end
   endtask

   initial begin
      cyc_t c;
      logic [18:0] obs;
      int n;

      gen_reset(2);
      gen_instr(7'h33, 0, 0, 1'b0, 1'b0, -1);   // ADD, CPI 4
      gen_instr(7'h33, 0, 0, 1'b0, 1'b1, -1);   // ADD with stray ready inputs
      gen_instr(7'h03, 0, 3, 1'b0, 1'b0, -1);   // LW, MEM held 4 cycles
      gen_instr(7'h13, 2, 0, 1'b0, 1'b1, -1);   // ADDI after slow fetch
      gen_instr(7'h63, 0, 0, 1'b1, 1'b0, -1);   // BEQ taken
      gen_instr(7'h63, 0, 0, 1'b0, 1'b1, -1);   // BEQ not taken
      gen_instr(7'h6F, 0, 0, 1'b0, 1'b0, -1);   // JAL
      gen_instr(7'h67, 0, 0, 1'b0, 1'b0, -1);   // JALR
      gen_instr(7'h23, 0, 1, 1'b0, 1'b1, -1);   // SW
      gen_instr(7'h37, 0, 0, 1'b0, 1'b0, -1);   // LUI: illegal class
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      gen_reset(1);
`endif
      gen_instr(7'h03, 0, 5, 1'b0, 1'b0, 1);    // LW abandoned by reset in MEM
      gen_instr(7'h33, 0, 0, 1'b0, 1'b0, -1);
      gen_instr(7'h03, 0, TO - 1, 1'b0, 1'b0, -1);  // dmem_ready on the last allowed cycle
      gen_instr(7'h33, TO - 1, 0, 1'b0, 1'b0, -1);  // imem_ready on the last allowed cycle
      gen_instr(7'h33, TO, 0, 1'b0, 1'b0, -1);      // fetch timeout
      gen_reset(1);
      gen_instr(7'h23, 0, TO, 1'b0, 1'b0, -1);      // store timeout in MEM
      gen_reset(2);
      gen_instr(7'h13, 0, 0, 1'b0, 1'b0, -1);

      n = 0;
      while (sbq.size() > 0) begin
         c = sbq.pop_front();
         reset      = c.rst;
         opcode     = c.opc;
         funct3     = 3'(n);
         imem_ready = c.ir;
         dmem_ready = c.dr;
         br_taken   = c.bt;
         @(negedge clk);
         obs = {state_o, ill_obs, timeout_err, instr_retired, wb_sel, reg_write, dmem_we,
                dmem_req, alu_op, alu_src_imm, pc_sel, pc_write, ir_write, imem_req};
         if (instr_retired === 1'b1) obs_ret++;
         check_eq($sformatf("cyc%0d_outs", n), 32'(obs), 32'(c.exp));
         n++;
         @(posedge clk);
         #1;
      end

      check_eq("retire_count", obs_ret, exp_ret);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
